// File: rtl/message_event_sequencer.sv
// message_event_sequencer
// Queues pick/deposit event pulses in a small FIFO and issues one trigger
// per event to the UART message transmitter. After each trigger it blocks
// for a full message plus a guard gap, so a message in flight is never
// restarted. The message select p only changes when an event is popped.
module message_event_sequencer #(
    parameter int FRAME_CLKS     = 434,
    parameter int MSG_CHARS      = 13,
    parameter int SLOTS_PER_CHAR = 11,
    parameter int GAP_CLKS       = 868,
    parameter int DEPTH          = 4
) (
    input  logic                         clk_50,
    input  logic                         rst,
    input  logic                         pick_evt,
    input  logic                         dep_evt,
    output logic                         trigger,
    output logic                         p,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow
);

    localparam int MSG_CLKS  = MSG_CHARS * SLOTS_PER_CHAR * FRAME_CLKS;
    localparam int HOLD_CLKS = MSG_CLKS + GAP_CLKS;
    localparam int CW        = $clog2(HOLD_CLKS + 1);
    localparam int PW        = $clog2(DEPTH);
    localparam int NW        = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_SEND = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic [NW-1:0]   free;
    logic            pop;
    logic            pick_acc, dep_acc;
    logic            p_q, p_d;
    logic            ovf_q, ovf_d;
    logic            trig_q, busy_q;

    // Sequencer: pop in IDLE, one FIRE cycle, then hold for HOLD_CLKS in SEND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    p_d     = mem_q[rptr_q];
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                cnt_d   = CW'(1);
                state_d = S_SEND;
            end
            S_SEND: begin
                if (cnt_q == CW'(HOLD_CLKS)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO enqueue: a same-cycle pop frees a slot; pick is written ahead of deposit.
    always_comb begin
        free     = NW'(DEPTH) - count_q + NW'(pop);
        pick_acc = pick_evt && (free != '0);
        dep_acc  = dep_evt && (free > (pick_acc ? NW'(1) : NW'(0)));
        ovf_d    = ovf_q | (pick_evt & ~pick_acc) | (dep_evt & ~dep_acc);
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        if (pick_acc) begin
            mem_d[wptr_d] = 1'b1;
            wptr_d        = wptr_d + PW'(1);
        end
        if (dep_acc) begin
            mem_d[wptr_d] = 1'b0;
            wptr_d        = wptr_d + PW'(1);
        end
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q - NW'(pop) + NW'(pick_acc) + NW'(dep_acc);
    end

    // State, FIFO and output registers. trigger/busy are registered images
    // of the FIRE/SEND states, so they lag the state by one clock.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mem_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            p_q     <= 1'b1;
            ovf_q   <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            trig_q  <= (state_q == S_FIRE);
            busy_q  <= (state_q == S_FIRE) || (state_q == S_SEND);
        end
    end

    assign trigger  = trig_q;
    assign busy     = busy_q;
    assign p        = p_q;
    assign pending  = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_message_event_sequencer.sv
// Bench for message_event_sequencer with shortened message timing.
// Reference model: a queue of events plus a count of clocks since the last
// pop; trigger/busy/next-pop timing are derived from that distance.
module tb_message_event_sequencer;

    localparam int FRAME = 2;
    localparam int CH    = 3;
    localparam int SL    = 2;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;
    localparam int HOLD  = CH * SL * FRAME + GAP;   // 16
    localparam int READY = HOLD + 2;                // clocks from one pop to the next

    logic       clk_50 = 1'b0;
    logic       rst = 1'b1;
    logic       pick_evt = 1'b0;
    logic       dep_evt = 1'b0;
    logic       trigger, p, busy, overflow;
    logic [2:0] pending;

    message_event_sequencer #(
        .FRAME_CLKS(FRAME), .MSG_CHARS(CH), .SLOTS_PER_CHAR(SL),
        .GAP_CLKS(GAP), .DEPTH(DEPTH)
    ) dut (
        .clk_50(clk_50), .rst(rst), .pick_evt(pick_evt), .dep_evt(dep_evt),
        .trigger(trigger), .p(p), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #10 clk_50 = ~clk_50;

    int n_chk  = 0;
    int n_pass = 0;
    int ntrig  = 0;

    // model state
    bit q[$];
    bit m_p   = 1'b1;
    bit m_ovf = 1'b0;
    int since = READY;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit pk, input bit dp);
        if (r) begin
            q.delete();
            m_p   = 1'b1;
            m_ovf = 1'b0;
            since = READY;
        end else begin
            if (since < READY) since++;
            if (since >= READY && q.size() > 0) begin
                m_p   = q.pop_front();
                since = 0;
            end
            if (pk) begin
                if (q.size() < DEPTH) q.push_back(1'b1); else m_ovf = 1'b1;
            end
            if (dp) begin
                if (q.size() < DEPTH) q.push_back(1'b0); else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit pk, input bit dp);
        rst = r; pick_evt = pk; dep_evt = dp;
        @(posedge clk_50);
        model_step(r, pk, dp);
        #1;
        chk("trigger",  int'(trigger),  int'(since == 1));
        chk("busy",     int'(busy),     int'(since >= 1 && since <= HOLD + 1));
        chk("p",        int'(p),        int'(m_p));
        chk("pending",  int'(pending),  q.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        if (trigger) ntrig++;
        rst = 1'b0; pick_evt = 1'b0; dep_evt = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
        chk("rst_pending", int'(pending), 0);
        chk("rst_p", int'(p), 1);

        // single pick
        cycle(1'b0, 1'b1, 1'b0);
        idle(READY + 4);

        // deposit, then pick a few cycles later
        cycle(1'b0, 1'b0, 1'b1);
        idle(5);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2 * READY + 4);

        // simultaneous pick and deposit with empty FIFO
        cycle(1'b0, 1'b1, 1'b1);
        chk("both_pending", int'(pending), 2);
        cycle(1'b0, 1'b0, 1'b0);
        chk("both_pop_pending", int'(pending), 1);
        idle(2 * READY + 4);

        // six events during one message: one dropped
        cycle(1'b1, 1'b0, 1'b0);
        ntrig = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, (i % 2) == 0, (i % 2) == 1);
            cycle(1'b0, 1'b0, 1'b0);
        end
        chk("six_overflow", int'(overflow), 1);
        chk("six_pending", int'(pending), 4);
        idle(5 * READY + 6);
        chk("six_trig_count", ntrig, 5);
        chk("six_overflow_sticky", int'(overflow), 1);

        // full FIFO: an event on the pop cycle is accepted
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4 * READY && since != HOLD + 1; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("pop_sync", since, HOLD + 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("full_pop_pending", int'(pending), 4);
        chk("full_pop_overflow", int'(overflow), 0);
        idle(5 * READY + 4);

        // reset in the middle of SEND with two queued
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        idle(8);
        cycle(1'b1, 1'b0, 1'b0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_pending", int'(pending), 0);
        ntrig = 0;
        idle(3 * READY);
        chk("abort_no_trig", ntrig, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/message_event_sequencer.md
# message_event_sequencer

Upstream sequencer for the pick/deposit UART message transmitter. It captures single-cycle pick and deposit event pulses from the arm controller and queues them in a 4-entry FIFO. It then issues one `trigger` pulse per event with `p` held stable, and blocks for the full message duration plus a guard gap. This prevents back-to-back events from restarting a message that is still being sent.

## Interface
- `FRAME_CLKS`, 434: clocks per UART bit slot (50 MHz / 115200).
- `MSG_CHARS`, 13: characters per message.
- `SLOTS_PER_CHAR`, 11: bit slots per character (idle, start, 8 data, stop).
- `GAP_CLKS`, 868: guard clocks after each message.
- `DEPTH`, 4: event FIFO entries (power of two).
- Derived: `MSG_CLKS = MSG_CHARS*SLOTS_PER_CHAR*FRAME_CLKS` (62062 at defaults).
- Derived: `HOLD_CLKS = MSG_CLKS + GAP_CLKS` (62930); the counter is 16 bits at defaults and `$clog2(HOLD_CLKS+1)` generally.

Ports:
- `clk_50`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `pick_evt`  in  1  one-cycle pulse: a pick occurred.
- `dep_evt`  in  1  one-cycle pulse: a deposit occurred.
- `trigger`  out  1  one-cycle start pulse to the transmitter.
- `p`  out  1  message select: 1 = pick, 0 = deposit; held for the whole message.
- `busy`  out  1  high from the trigger cycle until the hold ends.
- `pending`  out  3  FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: an event was dropped.

## Operation
- FIFO entry is 1 bit (1 = pick, 0 = deposit). It uses read/write pointers plus a count.
- Enqueue:
  - On a clock edge with an event high and count < DEPTH, write the entry.
  - If `pick_evt` and `dep_evt` are both high in the same cycle, write pick first, then deposit (2 entries).
  - If only one slot is free, store pick, drop deposit, and set `overflow`.
  - If the FIFO is full, drop all events that cycle and set `overflow`.
- Free space for a cycle = DEPTH − count + (1 if a pop happens that same cycle). A simultaneous pop frees a slot for that cycle's enqueue.
- State machine (registered):
  - IDLE: `busy`=0. If count > 0, pop the head, load `p` with the popped entry, and go to FIRE.
  - FIRE: `trigger`=1 and `busy`=1 for exactly one cycle. Load the counter with 1. Go to SEND.
  - SEND: `busy`=1; counter increments each cycle. When counter == HOLD_CLKS, go to IDLE.
  - Undefined state encodings go to IDLE.
- `p` changes only on a pop in IDLE. It holds its value through FIRE and SEND and afterwards, until the next pop. The transmitter samples `p` mid-message, so `p` must not change while `busy`=1.
- Events arriving during FIRE or SEND are queued and never dropped while space remains.
- `pending` reflects the count after the edge; it includes same-cycle enqueue and pop.

## Timing
- Reset values: `trigger`=0, `p`=1, `busy`=0, `pending`=0, `overflow`=0. State = IDLE, FIFO emptied, counter = 0.
- Reset has priority over every event in the same cycle, and events during reset are discarded. Reset in the middle of SEND aborts immediately: no trigger is issued and the next message starts fresh from IDLE.
- Latency with an empty FIFO and state IDLE:
  - Event sampled at edge k.
  - Pop and `p` update at edge k+1.
  - `trigger` high in the cycle following edge k+2.
- FIRE to the next possible FIRE: HOLD_CLKS + 2 cycles minimum (SEND duration, one IDLE cycle, then FIRE).
- `busy` spans 1 + HOLD_CLKS cycles per message.
- `overflow` clears only on `rst`.

## Test plan
- After reset, one `pick_evt`: `trigger` pulses once, 2 cycles after the event edge, with `p`=1. `busy` stays high for 62931 cycles, then `pending`=0.
- `dep_evt` followed 100 cycles later by `pick_evt`: first trigger has `p`=0. Second trigger has `p`=1 and comes exactly 62932 cycles after the first. `p` is constant while `busy`=1.
- Simultaneous `pick_evt` and `dep_evt` with the FIFO empty: `pending` goes 0→2→1 (pop). Triggers arrive in order pick, then deposit; `overflow`=0.
- Six single events during the first message: the first is popped immediately and 4 are queued, so `pending`=4. The sixth is dropped, `overflow`=1 and stays set. Exactly 5 triggers total.
- With `pending`=4 in IDLE, an event arrives on the pop cycle: it is accepted (`pending` stays 4) and `overflow` stays 0.
- `rst` asserted 1000 cycles into SEND with 2 events queued: next cycle all outputs are at reset values. No further trigger occurs until a new event arrives.
